// File: rtl/dmac_wr_burst_ctrl.sv
// Write-burst drain engine: holds one command until the buffer holds the whole burst, then AW, W beats, B.
// Latency: accept -> FILL -> ADDR -> DATA (len+1 beats) -> RESP; done_valid is combinational on the B handshake.
// Backpressure: AW waits on awready; W passes wready straight to buf_ready; one burst outstanding at a time.
module dmac_wr_burst_ctrl #(
  parameter int ADDR_WD       = 32,
  parameter int DATA_WD       = 32,
  parameter int CHANNEL_COUNT = 8,
  parameter int MAX_BURST_LEN = 16,
  localparam int CH_WD   = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
  localparam int LEN_WD  = $clog2(MAX_BURST_LEN),
  localparam int STRB_WD = DATA_WD / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ADDR_WD-1:0] cmd_addr,
  input  logic [LEN_WD-1:0]  cmd_len,
  input  logic [CH_WD-1:0]   cmd_ch,
  input  logic [LEN_WD:0]    buf_fill_level,
  input  logic               buf_valid,
  output logic               buf_ready,
  input  logic [DATA_WD-1:0] buf_data,
  output logic               awvalid,
  input  logic               awready,
  output logic [ADDR_WD-1:0] awaddr,
  output logic [7:0]         awlen,
  output logic [2:0]         awsize,
  output logic [1:0]         awburst,
  output logic               wvalid,
  input  logic               wready,
  output logic [DATA_WD-1:0] wdata,
  output logic [STRB_WD-1:0] wstrb,
  output logic               wlast,
  input  logic               bvalid,
  output logic               bready,
  input  logic [1:0]         bresp,
  output logic               done_valid,
  output logic [CH_WD-1:0]   done_ch,
  output logic               done_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [ADDR_WD-1:0] addr_q, addr_d;
  logic [LEN_WD-1:0]  len_q, len_d;
  logic [CH_WD-1:0]   ch_q, ch_d;
  logic [LEN_WD-1:0]  cnt_q, cnt_d;
  logic [CH_WD-1:0]   done_ch_q, done_ch_d;
  logic               done_err_q, done_err_d;

  logic               in_data;
  logic               w_hs;
  logic               b_hs;
  logic               fill_ok;
  logic [LEN_WD:0]    need_cnt;
  logic               unused_bresp0;

  // Only SLVERR/DECERR matter for completion status; bresp[0] carries no information here.
  assign unused_bresp0 = bresp[0];

  // Comparison is one bit wider than len so a maximum-length burst demands a completely full buffer.
  assign need_cnt = {1'b0, len_q} + 1'b1;
  assign fill_ok  = (buf_fill_level >= need_cnt);

  assign in_data = (state_q == S_DATA);
  assign w_hs    = wvalid & wready;
  assign b_hs    = (state_q == S_RESP) & bvalid;

  // Next-state, command capture, beat counting and completion status capture.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    ch_d       = ch_q;
    cnt_d      = cnt_q;
    done_ch_d  = done_ch_q;
    done_err_d = done_err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          ch_d    = cmd_ch;
          cnt_d   = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (fill_ok) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (awready) state_d = S_DATA;
      end
      S_DATA: begin
        if (w_hs) begin
          cnt_d = cnt_q + 1'b1;
          if (wlast) state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bvalid) begin
          done_ch_d  = ch_q;
          done_err_d = bresp[1];
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured-command registers; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      ch_q       <= '0;
      cnt_q      <= '0;
      done_ch_q  <= '0;
      done_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      ch_q       <= ch_d;
      cnt_q      <= cnt_d;
      done_ch_q  <= done_ch_d;
      done_err_q <= done_err_d;
    end
  end

  // cmd_ready is masked by rst so it reads low while reset is held.
  assign cmd_ready = (state_q == S_IDLE) & ~rst;

  assign awvalid = (state_q == S_ADDR);
  assign awaddr  = addr_q;
  assign awlen   = 8'(len_q);
  assign awsize  = 3'($clog2(STRB_WD));
  assign awburst = 2'b01;

  // W is a straight pass-through of the buffer read port while in DATA.
  assign wvalid    = in_data & buf_valid;
  assign buf_ready = in_data & wready;
  assign wdata     = buf_data;
  assign wstrb     = '1;
  assign wlast     = in_data & (cnt_q == len_q);

  assign bready     = (state_q == S_RESP);
  assign done_valid = b_hs;
  assign done_ch    = b_hs ? ch_q : done_ch_q;
  assign done_err   = b_hs ? bresp[1] : done_err_q;

endmodule

// File: tb/tb_dmac_wr_burst_ctrl.sv
// Directed bench for dmac_wr_burst_ctrl: a queue stands in for the burst buffer.
// Inputs are driven on the falling edge; outputs are sampled 1ns later, before the rising edge.
// Each scenario task runs its own comparisons against hand-computed values.
module tb_dmac_wr_burst_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [2:0]  cmd_ch;
  logic [4:0]  buf_fill_level;
  logic        buf_valid;
  logic        buf_ready;
  logic [31:0] buf_data;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        done_valid;
  logic [2:0]  done_ch;
  logic        done_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] bq[$];
  logic [31:0] got_data[$];
  bit          got_last[$];

  dmac_wr_burst_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_ch(cmd_ch),
    .buf_fill_level(buf_fill_level), .buf_valid(buf_valid),
    .buf_ready(buf_ready), .buf_data(buf_data),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .done_valid(done_valid), .done_ch(done_ch), .done_err(done_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) bq.push_back(base + 32'(i));
    buf_fill_level = 5'(bq.size());
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [3:0] l, input logic [2:0] c);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_ch = c;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_aw(output bit tmo);
    tmo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (awvalid) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic aw_hs();
    awready = 1'b1;
    @(posedge clk);
    #1;
    awready = 1'b0;
  endtask

  // Drives the W side from the buffer queue until the wlast handshake or the budget runs out.
  task automatic drain(input int wmode, input int gmode, input bit spur, input int budget,
                       output int pops, output int wv_bad, output bit bready_seen,
                       output bit done_seen, output bit tmo);
    bit popped;
    bit last_hs;
    pops = 0; wv_bad = 0; bready_seen = 1'b0; done_seen = 1'b0; tmo = 1'b1;
    got_data.delete();
    got_last.delete();
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      wready    = (wmode == 0) ? 1'b1 : ((cyc % 2) == 0);
      buf_valid = 1'b0;
      buf_data  = '0;
      if (bq.size() > 0 && !(gmode != 0 && (cyc % 3) == 1)) begin
        buf_valid = 1'b1;
        buf_data  = bq[0];
      end
      bvalid = spur;
      bresp  = spur ? 2'b10 : 2'b00;
      #1;
      if (bready) bready_seen = 1'b1;
      if (done_valid) done_seen = 1'b1;
      if (wvalid && !buf_valid) wv_bad++;
      popped  = buf_ready && buf_valid;
      if (popped) pops++;
      last_hs = wvalid && wready && wlast;
      if (wvalid && wready) begin
        got_data.push_back(wdata);
        got_last.push_back(wlast);
      end
      @(posedge clk);
      #1;
      if (popped) begin
        void'(bq.pop_front());
        buf_fill_level = 5'(bq.size());
      end
      if (last_hs) begin
        tmo = 1'b0;
        break;
      end
    end
    buf_valid = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({cmd_ready, awvalid, wvalid, wlast, bready, buf_ready, done_valid} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {cmd_ready, awvalid, wvalid, wlast, bready, buf_ready, done_valid});
    end
    total++;
    if ({awaddr, awlen} !== 40'h0) begin
      bad++;
      $display("FAIL reset_captured: awaddr=%h awlen=%h want 0", awaddr, awlen);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_cmd_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_reset_mid_data();
    bit tmo;
    bit dv_seen;
    load(32'h50, 4);
    send_cmd(32'h6000, 4'd3, 3'd4);
    wait_aw(tmo);
    total++;
    if (tmo) begin bad++; $display("FAIL rmid_aw_timeout: got none want awvalid"); end
    aw_hs();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      buf_valid = 1'b1; buf_data = bq[0]; wready = 1'b1;
      @(posedge clk);
      #1;
      void'(bq.pop_front());
    end
    @(negedge clk);
    buf_valid = 1'b1; buf_data = bq[0]; wready = 1'b1;
    rst = 1'b1;
    #1;
    total++;
    if ({cmd_ready, awvalid, wvalid, wlast, bready, buf_ready, done_valid} !== 7'b0) begin
      bad++;
      $display("FAIL rmid_outputs: got %b want 0000000",
               {cmd_ready, awvalid, wvalid, wlast, bready, buf_ready, done_valid});
    end
    total++;
    if (awaddr !== 32'h0) begin
      bad++;
      $display("FAIL rmid_addr_cleared: got %h want 00000000", awaddr);
    end
    @(negedge clk);
    rst = 1'b0; buf_valid = 1'b0; wready = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rmid_idle_ready: got %b want 1", cmd_ready);
    end
    dv_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bvalid = 1'b1;
      #1;
      if (done_valid || bready) dv_seen = 1'b1;
    end
    bvalid = 1'b0;
    total++;
    if (dv_seen !== 1'b0) begin
      bad++;
      $display("FAIL rmid_no_done: got %b want 0", dv_seen);
    end
    bq.delete();
    buf_fill_level = '0;
  endtask

  task automatic test_single_beat();
    bit tmo, brs, dns;
    int pops, wvb;
    load(32'hA0, 3);
    send_cmd(32'h1000, 4'd0, 3'd2);
    wait_aw(tmo);
    total++;
    if (tmo) begin bad++; $display("FAIL single_aw_timeout: got none want awvalid"); end
    total++;
    if ({awaddr, awlen, awsize, awburst} !== {32'h1000, 8'd0, 3'd2, 2'b01}) begin
      bad++;
      $display("FAIL single_aw_fields: got addr=%h len=%0d size=%0d burst=%0d want 1000/0/2/1",
               awaddr, awlen, awsize, awburst);
    end
    aw_hs();
    drain(0, 0, 1'b0, 20, pops, wvb, brs, dns, tmo);
    total++;
    if (tmo || got_data.size() != 1) begin
      bad++;
      $display("FAIL single_beats: got %0d beats (tmo=%0d) want 1", got_data.size(), tmo);
    end else begin
      total++;
      if ({got_data[0], got_last[0]} !== {32'hA0, 1'b1}) begin
        bad++;
        $display("FAIL single_beat_data: got %h last=%0d want 000000a0 last=1",
                 got_data[0], got_last[0]);
      end
    end
    total++;
    if (pops != 1 || bq.size() != 2) begin
      bad++;
      $display("FAIL single_pops: got pops=%0d left=%0d want 1/2", pops, bq.size());
    end
    @(negedge clk);
    bvalid = 1'b1; bresp = 2'b00;
    #1;
    total++;
    if ({bready, done_valid, done_ch, done_err} !== {1'b1, 1'b1, 3'd2, 1'b0}) begin
      bad++;
      $display("FAIL single_done: got bready=%b dv=%b ch=%0d err=%b want 1 1 2 0",
               bready, done_valid, done_ch, done_err);
    end
    @(negedge clk);
    bvalid = 1'b0;
    #1;
    total++;
    if ({done_valid, cmd_ready, done_ch} !== {1'b0, 1'b1, 3'd2}) begin
      bad++;
      $display("FAIL single_after_done: got dv=%b rdy=%b ch=%0d want 0 1 2",
               done_valid, cmd_ready, done_ch);
    end
    bq.delete();
    buf_fill_level = '0;
  endtask

  // Leaves the DUT in ADDR with a 16-entry buffer for test_full_burst.
  task automatic test_fill_gating();
    bit aw_early;
    buf_fill_level = '0;
    send_cmd(32'h2000, 4'd15, 3'd5);
    aw_early = 1'b0;
    for (int f = 0; f < 16; f++) begin
      @(negedge clk);
      buf_fill_level = 5'(f);
      #1;
      if (awvalid) aw_early = 1'b1;
    end
    total++;
    if (aw_early !== 1'b0) begin
      bad++;
      $display("FAIL fill_early_aw: got awvalid=1 want 0 below full");
    end
    @(negedge clk);
    load(32'h100, 16);
    #1;
    total++;
    if (awvalid !== 1'b0) begin
      bad++;
      $display("FAIL fill_same_cycle: got awvalid=%b want 0", awvalid);
    end
    @(negedge clk);
    #1;
    total++;
    if ({awvalid, awaddr, awlen} !== {1'b1, 32'h2000, 8'd15}) begin
      bad++;
      $display("FAIL fill_aw_next: got v=%b addr=%h len=%0d want 1 2000 15",
               awvalid, awaddr, awlen);
    end
  endtask

  task automatic test_full_burst();
    bit tmo, brs, dns;
    int pops, wvb;
    aw_hs();
    drain(1, 1, 1'b0, 200, pops, wvb, brs, dns, tmo);
    total++;
    if (tmo || got_data.size() != 16) begin
      bad++;
      $display("FAIL full_beats: got %0d beats (tmo=%0d) want 16", got_data.size(), tmo);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      total++;
      if ({got_data[i], got_last[i]} !== {32'h100 + 32'(i), (i == 15)}) begin
        bad++;
        $display("FAIL full_beat_%0d: got %h last=%0d want %h last=%0d",
                 i, got_data[i], got_last[i], 32'h100 + 32'(i), (i == 15));
      end
    end
    total++;
    if (pops != 16 || wvb != 0) begin
      bad++;
      $display("FAIL full_pops: got pops=%0d wvalid_without_data=%0d want 16/0", pops, wvb);
    end
    @(negedge clk);
    bvalid = 1'b1; bresp = 2'b01;
    #1;
    total++;
    if ({done_valid, done_ch, done_err} !== {1'b1, 3'd5, 1'b0}) begin
      bad++;
      $display("FAIL full_done: got dv=%b ch=%0d err=%b want 1 5 0", done_valid, done_ch, done_err);
    end
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
  endtask

  task automatic test_aw_stall_early_b();
    bit tmo, brs, dns;
    int pops, wvb;
    load(32'h200, 4);
    send_cmd(32'h3000_0040, 4'd3, 3'd7);
    wait_aw(tmo);
    total++;
    if (tmo) begin bad++; $display("FAIL stall_aw_timeout: got none want awvalid"); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      awready = 1'b0; buf_valid = 1'b1; buf_data = bq[0]; wready = 1'b1;
      #1;
      total++;
      if ({awvalid, awaddr, awlen, wvalid, buf_ready} !== {1'b1, 32'h3000_0040, 8'd3, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL stall_cycle_%0d: got v=%b addr=%h len=%0d wv=%b br=%b want 1 30000040 3 0 0",
                 i, awvalid, awaddr, awlen, wvalid, buf_ready);
      end
    end
    aw_hs();
    drain(0, 0, 1'b1, 20, pops, wvb, brs, dns, tmo);
    total++;
    if ({brs, dns} !== 2'b00) begin
      bad++;
      $display("FAIL stall_spurious_b: got bready_seen=%b done_seen=%b want 0 0", brs, dns);
    end
    total++;
    if (tmo || got_data.size() != 4 || pops != 4) begin
      bad++;
      $display("FAIL stall_beats: got beats=%0d pops=%0d tmo=%0d want 4 4 0",
               got_data.size(), pops, tmo);
    end else begin
      total++;
      if ({got_data[3], got_last[3], got_last[2]} !== {32'h203, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL stall_last_beat: got %h last=%0d prev_last=%0d want 00000203 1 0",
                 got_data[3], got_last[3], got_last[2]);
      end
    end
    @(negedge clk);
    bvalid = 1'b1; bresp = 2'b00;
    #1;
    total++;
    if ({done_valid, done_ch, done_err} !== {1'b1, 3'd7, 1'b0}) begin
      bad++;
      $display("FAIL stall_done: got dv=%b ch=%0d err=%b want 1 7 0", done_valid, done_ch, done_err);
    end
    @(negedge clk);
    bvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit tmo, brs, dns;
    int pops, wvb;
    load(32'h300, 2);
    load(32'h400, 1);
    send_cmd(32'h4000, 4'd1, 3'd1);
    wait_aw(tmo);
    total++;
    if (tmo) begin bad++; $display("FAIL b2b_aw1_timeout: got none want awvalid"); end
    aw_hs();
    drain(0, 0, 1'b0, 20, pops, wvb, brs, dns, tmo);
    total++;
    if (tmo || got_data.size() != 2 || bq.size() != 1) begin
      bad++;
      $display("FAIL b2b_first_beats: got beats=%0d left=%0d want 2 1", got_data.size(), bq.size());
    end
    @(negedge clk);
    bvalid = 1'b1; bresp = 2'b10;
    cmd_valid = 1'b1; cmd_addr = 32'h5000; cmd_len = 4'd0; cmd_ch = 3'd3;
    #1;
    total++;
    if ({done_valid, done_ch, done_err, cmd_ready} !== {1'b1, 3'd1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL b2b_err_done: got dv=%b ch=%0d err=%b rdy=%b want 1 1 1 0",
               done_valid, done_ch, done_err, cmd_ready);
    end
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
    #1;
    total++;
    if ({cmd_ready, done_valid, done_ch, done_err} !== {1'b1, 1'b0, 3'd1, 1'b1}) begin
      bad++;
      $display("FAIL b2b_accept_hold: got rdy=%b dv=%b ch=%0d err=%b want 1 0 1 1",
               cmd_ready, done_valid, done_ch, done_err);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_aw(tmo);
    total++;
    if (tmo || {awaddr, awlen} !== {32'h5000, 8'd0}) begin
      bad++;
      $display("FAIL b2b_aw2: got addr=%h len=%0d tmo=%0d want 5000 0 0", awaddr, awlen, tmo);
    end
    aw_hs();
    drain(0, 0, 1'b0, 20, pops, wvb, brs, dns, tmo);
    total++;
    if (tmo || got_data.size() != 1 || got_data[0] !== 32'h400) begin
      bad++;
      $display("FAIL b2b_second_beat: got beats=%0d tmo=%0d want one beat 00000400",
               got_data.size(), tmo);
    end
    @(negedge clk);
    bvalid = 1'b1;
    #1;
    total++;
    if ({done_valid, done_ch, done_err} !== {1'b1, 3'd3, 1'b0}) begin
      bad++;
      $display("FAIL b2b_second_done: got dv=%b ch=%0d err=%b want 1 3 0", done_valid, done_ch, done_err);
    end
    @(negedge clk);
    bvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_ch = '0;
    buf_fill_level = '0; buf_valid = 1'b0; buf_data = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    test_reset();
    test_reset_mid_data();
    test_single_beat();
    test_fill_gating();
    test_full_burst();
    test_aw_stall_early_b();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmac_wr_burst_ctrl.md
Name: dmac_wr_burst_ctrl

Overview:
- Write-side drain engine for the per-burst data buffer; sits on the buffer's output (read) port and the AXI4 master write channels (AW/W/B).
- Accepts one burst command at a time and holds it until the buffer contains the whole burst.
- Then issues AW, streams W beats from the buffer with a correctly placed wlast, collects B, and reports completion per channel.

Parameters:
- ADDR_WD, 32, AXI address width.
- DATA_WD, 32, AXI data width; a multiple of 8.
- CHANNEL_COUNT, 8, number of DMA channels; sets CH_WD = max(1,$clog2(CHANNEL_COUNT)).
- MAX_BURST_LEN, 16, maximum beats per burst; power of 2, at most 256; LEN_WD = $clog2(MAX_BURST_LEN).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_addr  in  ADDR_WD  burst start address.
- cmd_len  in  LEN_WD  beats minus 1.
- cmd_ch  in  CH_WD  issuing channel.
- buf_fill_level  in  LEN_WD+1  buffer entry count.
- buf_valid  in  1  buffer read data valid.
- buf_ready  out  1  buffer read strobe.
- buf_data  in  DATA_WD  buffer read data.
- awvalid  out  1  AXI AW valid.
- awready  in  1  AXI AW ready.
- awaddr  out  ADDR_WD  AXI AW address.
- awlen  out  8  AXI AW length.
- awsize  out  3  AXI AW size.
- awburst  out  2  AXI AW burst type.
- wvalid  out  1  AXI W valid.
- wready  in  1  AXI W ready.
- wdata  out  DATA_WD  AXI W data.
- wstrb  out  DATA_WD/8  AXI W byte strobes.
- wlast  out  1  AXI W last beat.
- bvalid  in  1  AXI B valid.
- bready  out  1  AXI B ready.
- bresp  in  2  AXI B response.
- done_valid  out  1  completion event, single-cycle pulse.
- done_ch  out  CH_WD  channel of the completed burst.
- done_err  out  1  high when bresp[1] was set (SLVERR/DECERR).

Behaviour:
- Reset (async assert, deasserted synchronously to clk by the system): state IDLE.
  - All valid, ready and last outputs are 0: cmd_ready, awvalid, wvalid, wlast, bready, buf_ready, done_valid.
  - Captured addr/len/ch registers and the beat counter are 0.
- Reset mid-burst abandons the transaction; no done_valid is generated.
- FSM states: IDLE, FILL, ADDR, DATA, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: capture addr/len/ch, clear the beat counter, go to FILL next cycle.
- FILL:
  - Wait until buf_fill_level >= cmd_len+1. The comparison is done at LEN_WD+1 bits, so len = MAX_BURST_LEN-1 requires a full buffer.
  - When satisfied, go to ADDR.
- ADDR:
  - awvalid = 1; awaddr and awlen are registered values.
  - awlen = zero-extended len; awsize = $clog2(DATA_WD/8); awburst = 2'b01 (INCR).
  - awaddr/awlen stay stable while awvalid && !awready.
  - On awready, go to DATA.
- DATA (W is never issued before AW completes):
  - wvalid = buf_valid; buf_ready = wready (combinational pass-through).
  - wdata = buf_data; wstrb = all ones.
  - wlast = (beat counter == len).
  - The beat counter increments on each wvalid && wready.
  - On the handshake with wlast = 1: go to RESP and stop reading the buffer. No extra buffer pop occurs.
  - A buf_valid drop mid-burst stalls W; wvalid is never asserted without data.
- RESP:
  - bready = 1. On bvalid, assert done_valid for exactly one cycle with done_ch = captured ch and done_err = bresp[1].
  - Return to IDLE in the same transition, so a new command is accepted the cycle after done_valid.
- Idle-time outputs: done_ch and done_err hold their last value when done_valid = 0.
- Throughput: at most one outstanding burst. Minimum cycles from command acceptance to done_valid = 3 + (len+1) + B latency.
- Boundary cases:
  - len = 0 gives a single beat with wlast asserted on it.
  - buf_fill_level larger than required does not alter the beat count.
  - bvalid during ADDR or DATA is ignored: bready = 0 there.

Test Plan:
- Reset mid-DATA: cmd len=3, reset after 2 W beats → all outputs 0 immediately; after release, state IDLE with cmd_ready=1 and no done_valid.
- Single beat: cmd addr=0x1000, len=0, ch=2, fill=1 → AW with awaddr=0x1000, awlen=0, awsize=2, awburst=1; one W beat with wlast=1; bresp=0 → done_valid pulse, done_ch=2, done_err=0.
- Fill gating: cmd len=15 with fill rising 0→15 → no awvalid; fill=16 → awvalid next cycle.
- Full burst with backpressure: len=15, wready toggling 50% and buf_valid gapped → exactly 16 W beats, data in order, wlast only on beat 16, exactly 16 buffer pops.
- AW stall and early B: awready held low for 5 cycles → awaddr/awlen stable and wvalid=0; a spurious bvalid during DATA → ignored, bready=0.
- Error and back-to-back: bresp=2'b10 → done_err=1; a second cmd presented at done → accepted the next cycle, and its AW reflects the new address.
